alu_arb_ctrl: RTL
=================

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; SHALL match the shared ALU width.
REQ-002 Parameter OP_W, default 4, opcode width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester operation request (bit i = requester i).
REQ-006 req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-007 req_a, req_b  input  2*DATA_W each  operands; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_op  input  2*OP_W  opcodes; requester i occupies bits [i*OP_W +: OP_W].
REQ-009 rsp_valid  output  2  one-hot response valid to the requester that issued the operation.
REQ-010 rsp_ready  input  2  per-requester response accept.
REQ-011 rsp_result  output  DATA_W  shared result bus, meaningful only while a rsp_valid bit is high.
REQ-012 rsp_zero, rsp_err  output  1 each  zero flag and illegal-opcode flag, qualified by rsp_valid.
REQ-013 alu_a, alu_b  output  DATA_W each; alu_op  output  OP_W  registered drive to the shared ALU.
REQ-014 alu_result  input  DATA_W; alu_zero  input  1  ALU outputs, one-cycle registered latency.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, RESP.
REQ-017 In IDLE, req_ready SHALL be asserted only for the granted requester, combinationally from req_valid and the priority pointer.
REQ-018 Arbitration SHALL be round-robin: sole valid requester wins; with both valid, the requester not granted last wins.
REQ-019 On the req handshake, the operands and opcode SHALL be latched into alu_a/alu_b/alu_op, the requester ID stored, the pointer updated, and the FSM SHALL move to EXEC.
REQ-020 EXEC SHALL last exactly one cycle and then move to RESP.
REQ-021 In RESP, rsp_valid[id] SHALL be high, with rsp_result = alu_result and rsp_zero = alu_zero; the first rsp_valid cycle SHALL be two cycles after the handshake edge.
REQ-022 alu_a/alu_b/alu_op SHALL hold constant from the handshake until the FSM returns to IDLE, so rsp_result stays stable under backpressure.
REQ-023 RESP SHALL hold until rsp_ready[id] is high, then the FSM SHALL return to IDLE; the next acceptance SHALL occur no earlier than the IDLE cycle (minimum 3 cycles per operation).
REQ-024 rsp_ready on the non-owning bit SHALL be ignored.
REQ-025 req_valid deasserting while the FSM is not in IDLE SHALL have no effect; no request is queued.
REQ-026 rsp_valid, rsp_result, rsp_zero and rsp_err SHALL be 0 outside RESP.

Reset
REQ-027 On reset assertion, state SHALL be IDLE and busy, req_ready, rsp_valid, rsp_err, alu_a, alu_b and alu_op SHALL all be 0.
REQ-028 On reset assertion, the pointer SHALL be set to "last granted = 1", so requester 0 wins the first contention.
REQ-029 Reset during EXEC or RESP SHALL abort the operation with no response delivered.

Configuration
REQ-030 Macro ALU_ARB_OPCHK_EN defined: opcodes above 4'b1000 SHALL be accepted with unchanged timing, but alu_op and the operands SHALL be driven 0.
REQ-031 With ALU_ARB_OPCHK_EN defined and such an opcode, the response SHALL give rsp_err=1, rsp_result=0, rsp_zero=0.
REQ-032 Macro ALU_ARB_OPCHK_EN undefined: all opcodes SHALL be forwarded unchanged and rsp_err SHALL be tied 0.

Verification
REQ-033 Single op: req0 a=5, b=3, op=0000 -> req_ready[0] same cycle; two cycles later rsp_valid=01, rsp_result=8, rsp_zero=0.
REQ-034 Contention after reset: both valid, req0 op=0001 a=b=7, req1 op=1000 a=-1, b=0 -> req0 served first with result 0 and zero 1; req1 served next with result 1.
REQ-035 Backpressure: req1 op=0101 a=1, b=4, rsp_ready low 5 cycles -> rsp_valid=10 held with result 16 stable, busy=1, req_ready=00 throughout.
REQ-036 Illegal op 1111, a=9, b=9 -> with ALU_ARB_OPCHK_EN: rsp_err=1, result 0, zero 0; without it: rsp_err=0, result 0, zero 1.
REQ-037 Reset asserted in RESP -> same cycle rsp_valid=00, busy=0; after release, a new req0 op is accepted normally.
REQ-038 Continuous both-valid traffic for 6 operations -> grants strictly alternate 0,1,0,1,0,1, each 3 cycles apart.

Source files
------------

// File: rtl/alu_arb_ctrl_if.sv
// Bundle of the requester handshake and shared-ALU signals around alu_arb_ctrl.
// The slave modport is the arbiter side; the master modport is the requesters plus the ALU.
interface alu_arb_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_a;
    logic [2*DATA_W-1:0] req_b;
    logic [2*OP_W-1:0]   req_op;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [DATA_W-1:0]   rsp_result;
    logic                rsp_zero;
    logic                rsp_err;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [OP_W-1:0]     alu_op;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_zero,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_op
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_zero,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_arb_ctrl.sv
// Round-robin arbiter sharing one registered-latency ALU between two requesters.
// Optional macro ALU_ARB_OPCHK_EN: opcodes above 4'b1000 are squashed and flagged via rsp_err.
module alu_arb_ctrl #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic           clk,
    input  logic           reset,
    alu_arb_ctrl_if.slave  bus,
    output logic           busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_q;
    logic              id_q;
    logic              err_q;
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [OP_W-1:0]   alu_op_q;

    logic              handshake;
    logic              grant_id;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [OP_W-1:0]   sel_op;
    logic              op_bad;
    logic              in_resp;

    // Grant only in IDLE; on contention the requester not served last wins.
    always_comb begin
        handshake = 1'b0;
        grant_id  = 1'b0;
        if (state_q == IDLE) begin
            case (bus.req_valid)
                2'b01: begin
                    handshake = 1'b1;
                    grant_id  = 1'b0;
                end
                2'b10: begin
                    handshake = 1'b1;
                    grant_id  = 1'b1;
                end
                2'b11: begin
                    handshake = 1'b1;
                    grant_id  = ~last_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = handshake ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    assign sel_a  = grant_id ? bus.req_a[2*DATA_W-1:DATA_W] : bus.req_a[DATA_W-1:0];
    assign sel_b  = grant_id ? bus.req_b[2*DATA_W-1:DATA_W] : bus.req_b[DATA_W-1:0];
    assign sel_op = grant_id ? bus.req_op[2*OP_W-1:OP_W]    : bus.req_op[OP_W-1:0];

`ifdef ALU_ARB_OPCHK_EN
    assign op_bad = (sel_op > OP_W'(8));
`else
    assign op_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready[id_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            err_q    <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
        end else begin
            state_q <= state_d;
            // ALU drive stays frozen until the next handshake so the result holds under backpressure.
            if (handshake) begin
                id_q     <= grant_id;
                last_q   <= grant_id;
                err_q    <= op_bad;
                alu_a_q  <= op_bad ? '0 : sel_a;
                alu_b_q  <= op_bad ? '0 : sel_b;
                alu_op_q <= op_bad ? '0 : sel_op;
            end
        end
    end

    assign in_resp = (state_q == RESP);
    assign busy    = (state_q != IDLE);

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.rsp_valid  = in_resp ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_result = (in_resp && !err_q) ? bus.alu_result : '0;
    assign bus.rsp_zero   = in_resp && !err_q && bus.alu_zero;
    assign bus.rsp_err    = in_resp && err_q;

endmodule
